// File: rtl/counter_bank_pkg.sv
// Shared definitions for the counter bank: per-channel operation encoding
// and the supported parameter ranges.
package counter_bank_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_INC  = 3'd2,
    OP_DEC  = 3'd3,
    OP_TICK = 3'd4
  } op_e;

  localparam int N_CH_MIN  = 1;
  localparam int N_CH_MAX  = 16;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/counter_bank_ch.sv
// One counter channel: priority operation select, wrap/saturate arithmetic,
// overflow pulse, zero flag and match edge detection.
module counter_bank_ch
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             up,
  input  logic             down,
  input  logic             saturate,
  input  logic             tick,
  input  logic [WIDTH-1:0] match_val,
  output logic [WIDTH-1:0] count,
  output logic             eq_zero,
  output logic             match_hit,
  output logic             ovf_pulse
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  op_e              op;
  logic [WIDTH-1:0] count_next;
  logic             ovf_next;
  logic             m;
  logic             m_q;

  // A strobe outranks the tick, so a tick landing with a strobe is dropped.
  always_comb begin
    op = OP_HOLD;
    if (clear)              op = OP_CLR;
    else if (up && down)    op = OP_HOLD;
    else if (up)            op = OP_INC;
    else if (down)          op = OP_DEC;
    else if (tick && enable) op = OP_TICK;
  end

  always_comb begin
    count_next = count;
    ovf_next   = 1'b0;
    case (op)
      OP_CLR: count_next = '0;
      OP_INC, OP_TICK: begin
        if (count == MAX_VAL) begin
          ovf_next   = 1'b1;
          count_next = saturate ? MAX_VAL : '0;
        end else begin
          count_next = count + ONE;
        end
      end
      OP_DEC: begin
        if (count == '0) begin
          ovf_next   = 1'b1;
          count_next = saturate ? '0 : MAX_VAL;
        end else begin
          count_next = count - ONE;
        end
      end
      default: count_next = count;
    endcase
  end

  assign m = (count == match_val);

  // m_q resets high so a zero match value does not fire right after reset.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      ovf_pulse <= 1'b0;
      eq_zero   <= 1'b1;
      m_q       <= 1'b1;
      match_hit <= 1'b0;
    end else begin
      count     <= count_next;
      ovf_pulse <= ovf_next;
      eq_zero   <= (count == '0);
      m_q       <= m;
      match_hit <= m & ~m_q;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// Bank of N_CH up/down counters sharing one reloadable prescaler whose
// registered tick drives each channel's auto-count.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 24
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  div_load,
  input  logic [N_CH-1:0]       ch_clear,
  input  logic [N_CH-1:0]       ch_enable,
  input  logic [N_CH-1:0]       ch_up,
  input  logic [N_CH-1:0]       ch_down,
  input  logic [N_CH-1:0]       ch_saturate,
  input  logic [N_CH*WIDTH-1:0] ch_match,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       eq_zero,
  output logic [N_CH-1:0]       match_hit,
  output logic [N_CH-1:0]       ovf_pulse,
  output logic                  tick
);

  logic [DIV_WIDTH-1:0] div;

  // div_load is only sampled on reload, so a new period starts cleanly.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      div  <= '0;
      tick <= 1'b0;
    end else if (div == '0) begin
      div  <= div_load;
      tick <= 1'b1;
    end else begin
      div  <= div - DIV_WIDTH'(1);
      tick <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    counter_bank_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .clear    (ch_clear[i]),
      .enable   (ch_enable[i]),
      .up       (ch_up[i]),
      .down     (ch_down[i]),
      .saturate (ch_saturate[i]),
      .tick     (tick),
      .match_val(ch_match[i*WIDTH +: WIDTH]),
      .count    (count[i*WIDTH +: WIDTH]),
      .eq_zero  (eq_zero[i]),
      .match_hit(match_hit[i]),
      .ovf_pulse(ovf_pulse[i])
    );
  end

endmodule
